// File: rtl/game_state_controller.sv
// game_state_controller: synchronised button/collision events drive the MENU/RUN/PAUSE/OVER game FSM,
// score, lives, player radius and the post-hit immunity timer.
module game_state_controller #(
    parameter int START_LIVES   = 3,
    parameter int WIN_SCORE     = 8,
    parameter int R_INIT        = 10,
    parameter int R_STEP        = 2,
    parameter int R_MAX         = 60,
    parameter int INVULN_CYCLES = 100000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       food_collide,
    input  logic [3:0] enemy_collide,
    output logic       gamemenu,
    output logic       gamerun,
    output logic       gamepause,
    output logic       gameover,
    output logic       win,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic [9:0] player_r,
    output logic       invuln
);
    localparam int TW = $clog2(INVULN_CYCLES + 1);
    localparam logic [TW-1:0] T_LOAD = TW'(INVULN_CYCLES);
    localparam logic [10:0] R_MAX11 = 11'(R_MAX);
    localparam logic [10:0] R_STEP11 = 11'(R_STEP);

    typedef enum logic [1:0] {MENU, RUN, PAUSE, OVER} state_t;

    state_t state, state_n;
    logic [6:0] raw, s1, s2, hist, armed, ev;
    logic [1:0] fill;
    logic [TW-1:0] timer, timer_n;
    logic [7:0] score_n;
    logic [1:0] lives_n;
    logic [9:0] r_n;
    logic [10:0] r_sum;
    logic win_n, hit;

    assign raw = {enemy_collide, food_collide, btn_pause, btn_start};
    // armed stays low after reset until the synchronised level is seen low, so held levels make no event
    assign ev = s2 & ~hist & armed;
    assign r_sum = {1'b0, player_r} + R_STEP11;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= '0;
            s2    <= '0;
            hist  <= '0;
            armed <= '0;
            fill  <= '0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            hist  <= s2;
            fill  <= fill + {1'b0, fill != 2'd2};
            if (fill == 2'd2) armed <= armed | ~s2;
        end
    end

    always_comb begin
        state_n = state;
        score_n = score;
        lives_n = lives;
        r_n     = player_r;
        timer_n = timer;
        win_n   = win;
        hit     = 1'b0;
        case (state)
            MENU: if (ev[0]) begin
                state_n = RUN;
                score_n = '0;
                lives_n = 2'(START_LIVES);
                r_n     = 10'(R_INIT);
                timer_n = '0;
                win_n   = 1'b0;
            end
            RUN: begin
                hit     = |ev[6:3] && timer == '0;
                timer_n = hit ? T_LOAD : (timer != '0 ? timer - TW'(1) : timer);
                if (hit) lives_n = lives - 2'd1;
                if (ev[2]) begin
                    score_n = score == 8'hFF ? score : score + 8'd1;
                    r_n     = r_sum > R_MAX11 ? R_MAX11[9:0] : r_sum[9:0];
                end
                // loss outranks win, and both outrank pause
                if (hit && lives == 2'd1) state_n = OVER;
                else if (ev[2] && score_n == 8'(WIN_SCORE)) begin
                    state_n = OVER;
                    win_n   = 1'b1;
                end else if (ev[1]) state_n = PAUSE;
            end
            PAUSE: state_n = ev[0] ? MENU : (ev[1] ? RUN : PAUSE);
            OVER: if (ev[0]) begin
                state_n = MENU;
                win_n   = 1'b0;
            end
            default: state_n = MENU;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= MENU;
            gamemenu  <= 1'b1;
            gamerun   <= 1'b0;
            gamepause <= 1'b0;
            gameover  <= 1'b0;
            win       <= 1'b0;
            score     <= '0;
            lives     <= 2'(START_LIVES);
            player_r  <= 10'(R_INIT);
            timer     <= '0;
            invuln    <= 1'b0;
        end else begin
            state     <= state_n;
            gamemenu  <= state_n == MENU;
            gamerun   <= state_n == RUN;
            gamepause <= state_n == PAUSE;
            gameover  <= state_n == OVER;
            win       <= win_n;
            score     <= score_n;
            lives     <= lives_n;
            player_r  <= r_n;
            timer     <= timer_n;
            invuln    <= timer_n != '0;
        end
    end
endmodule

// File: tb/tb_game_state_controller.sv
// tb_game_state_controller: directed checks of game_state_controller via a negedge compare queue
module tb_game_state_controller;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_start = 1'b0, btn_pause = 1'b0, food_collide = 1'b0;
  logic [3:0] enemy_collide = 4'b0;
  logic       gamemenu, gamerun, gamepause, gameover, win, invuln;
  logic [7:0] score;
  logic [1:0] lives;
  logic [9:0] player_r;
  typedef struct {
    string name;
    int    id;
    int    exp;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int compared = 0;
  int mismatched = 0;
  game_state_controller #(
    .START_LIVES(3), .WIN_SCORE(8), .R_INIT(10), .R_STEP(2), .R_MAX(60), .INVULN_CYCLES(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_pause(btn_pause),
    .food_collide(food_collide), .enemy_collide(enemy_collide),
    .gamemenu(gamemenu), .gamerun(gamerun), .gamepause(gamepause), .gameover(gameover),
    .win(win), .score(score), .lives(lives), .player_r(player_r), .invuln(invuln)
  );
  always #5 clk = ~clk;
  function automatic int dut_val(int id);
    case (id)
      0: return int'(gamemenu);
      1: return int'(gamerun);
      2: return int'(gamepause);
      3: return int'(gameover);
      4: return int'(win);
      5: return int'(score);
      6: return int'(lives);
      7: return int'(player_r);
      default: return int'(invuln);
    endcase
  endfunction
  always @(negedge clk) begin
    while (q.size() > 0) begin
      e = q.pop_front();
      compared++;
      if (dut_val(e.id) != e.exp) begin
        mismatched++;
        $display("FAIL %s: got %0d, expected %0d", e.name, dut_val(e.id), e.exp);
      end
    end
  end
  task automatic chk(string n, int id, int v);
    q.push_back('{n, id, v});
  endtask
  task automatic flags(string n, int m, int r, int p, int o);
    chk({n, ".gamemenu"}, 0, m);
    chk({n, ".gamerun"}, 1, r);
    chk({n, ".gamepause"}, 2, p);
    chk({n, ".gameover"}, 3, o);
  endtask
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic counts(string n, int s, int l, int r);
    chk({n, ".score"}, 5, s);
    chk({n, ".lives"}, 6, l);
    chk({n, ".player_r"}, 7, r);
  endtask
  initial begin
    #1;
    flags("rst", 1, 0, 0, 0);
    chk("rst.win", 4, 0);
    chk("rst.invuln", 8, 0);
    counts("rst", 0, 3, 10);
    tick(2);
    rst_n = 1'b1;
    tick(5);
    btn_start = 1'b1;
    tick(2);
    flags("start_lat2", 1, 0, 0, 0);
    tick(1);
    flags("start_lat3", 0, 1, 0, 0);
    counts("start", 0, 3, 10);
    btn_start = 1'b0;
    tick(3);
    btn_start = 1'b1;
    tick(3);
    flags("start_in_run", 0, 1, 0, 0);
    btn_start = 1'b0;
    tick(3);
    food_collide = 1'b1;
    tick(3);
    counts("food1", 1, 3, 12);
    tick(47);
    counts("food_held", 1, 3, 12);
    food_collide = 1'b0;
    tick(3);
    enemy_collide = 4'b0011;
    tick(3);
    chk("hit.lives", 6, 2);
    chk("hit.invuln", 8, 1);
    tick(5);
    enemy_collide = 4'b0111;
    tick(2);
    btn_pause = 1'b1;
    tick(1);
    chk("immune.lives", 6, 2);
    tick(2);
    flags("paused", 0, 0, 1, 0);
    chk("paused.invuln", 8, 1);
    btn_pause = 1'b0;
    tick(100);
    flags("pause_hold", 0, 0, 1, 0);
    chk("pause_hold.invuln", 8, 1);
    chk("pause_hold.lives", 6, 2);
    btn_pause = 1'b1;
    tick(3);
    flags("resume", 0, 1, 0, 0);
    chk("resume.invuln", 8, 1);
    btn_pause = 1'b0;
    tick(9);
    chk("invuln_last", 8, 1);
    tick(1);
    chk("invuln_drop", 8, 0);
    enemy_collide = 4'b0;
    tick(3);
    for (int i = 2; i <= 8; i++) begin
      food_collide = 1'b1;
      tick(3);
      chk($sformatf("food%0d.score", i), 5, i);
      chk($sformatf("food%0d.r", i), 7, 10 + 2 * i);
      food_collide = 1'b0;
      tick(3);
    end
    flags("won", 0, 0, 0, 1);
    chk("won.win", 4, 1);
    btn_start = 1'b1;
    tick(3);
    flags("over_to_menu", 1, 0, 0, 0);
    chk("menu.win", 4, 0);
    btn_start = 1'b0;
    tick(3);
    btn_start = 1'b1;
    tick(3);
    flags("restart", 0, 1, 0, 0);
    counts("restart", 0, 3, 10);
    btn_start = 1'b0;
    tick(3);
    for (int i = 2; i >= 1; i--) begin
      enemy_collide = 4'b0001;
      tick(3);
      chk($sformatf("lives%0d", i), 6, i);
      enemy_collide = 4'b0;
      tick(25);
    end
    food_collide = 1'b1;
    enemy_collide = 4'b1000;
    tick(3);
    flags("lost", 0, 0, 0, 1);
    chk("lost.win", 4, 0);
    counts("lost", 1, 0, 12);
    food_collide = 1'b0;
    enemy_collide = 4'b0;
    tick(3);
    btn_start = 1'b1;
    tick(3);
    btn_start = 1'b0;
    tick(3);
    btn_start = 1'b1;
    tick(3);
    btn_start = 1'b0;
    tick(3);
    food_collide = 1'b1;
    tick(3);
    chk("pre_rst.score", 5, 1);
    food_collide = 1'b0;
    btn_start = 1'b1;
    tick(2);
    rst_n = 1'b0;
    #1;
    flags("async_rst", 1, 0, 0, 0);
    counts("async_rst", 0, 3, 10);
    tick(1);
    rst_n = 1'b1;
    tick(10);
    flags("held_start", 1, 0, 0, 0);
    btn_start = 1'b0;
    tick(4);
    btn_start = 1'b1;
    tick(3);
    flags("rearmed_start", 0, 1, 0, 0);
    if (gamerun !== 1'b1 || gamemenu !== 1'b0) begin
      mismatched++;
      $display("FAIL direct rearmed_start: gamerun=%0b gamemenu=%0b, expected 1/0", gamerun, gamemenu);
    end
    btn_start = 1'b0;
    tick(3);
    if (mismatched != 0) $display("FAIL: %0d mismatches", mismatched);
    if (compared < 12) begin
      mismatched++;
      $display("FAIL: only %0d comparisons made, expected at least 12", compared);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
